// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
// Per-frame ball sequencer for the breakout playfield. Each accepted frame
// tick computes the ball's next position and presents it to the external
// brick lookup. The lookup result is registered one cycle later. The frame is
// then evaluated for wall, paddle and brick collisions and committed.
//
// Ports:
//   clk, resetn        single clock, asynchronous active-low reset
//   frame_tick         one-cycle frame pulse; only honoured in WAIT
//   start              launch / relaunch request; only honoured in IDLE, LOST, WIN
//   paddle_x           paddle left edge
//   probe_x, probe_y   next ball position presented to the brick lookup
//   probe_brick        lookup result; 0..11 brick index, >=12 no brick
//   ball_x, ball_y     committed ball position
//   dir                bit0: 1 = -x, bit1: 1 = up (-y)
//   bricks_alive       one bit per brick, 1 = present
//   busy               high in PROBE and EVAL
//   done               one-cycle pulse in the cycle after EVAL
//   lost, win          level outputs for the LOST / WIN states
//   dbg_state          current FSM state, for observation only
//
// Handshake: there is no back-pressure. A frame_tick is consumed only when the
// FSM sits in WAIT; pulses arriving in any other state are dropped. The same
// applies to start outside IDLE / LOST / WIN.
module ball_motion_ctrl #(
  parameter int XSTEP    = 4,
  parameter int YSTEP    = 4,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int PADDLE_Y = 440,
  parameter int PADDLE_W = 80,
  parameter int START_X  = 320,
  parameter int START_Y  = 400
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [9:0]  paddle_x,
  output logic [9:0]  probe_x,
  output logic [9:0]  probe_y,
  input  logic [3:0]  probe_brick,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [1:0]  dir,
  output logic [11:0] bricks_alive,
  output logic        busy,
  output logic        done,
  output logic        lost,
  output logic        win,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_PROBE = 3'd2,
    S_EVAL  = 3'd3,
    S_LOST  = 3'd4,
    S_WIN   = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;
  logic [1:0]  r_dir;
  logic [11:0] r_alive;
  logic [9:0]  r_probe_x;
  logic [9:0]  r_probe_y;
  logic [3:0]  r_hit;
  logic        r_done;

  // Next position in 11-bit signed form so a step past zero reads as negative
  // instead of wrapping to a large coordinate. The ball does not move between
  // WAIT and EVAL, so the same values are valid for the probe and the evaluation.
  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic signed [11:0] w_nx_ext;
  logic signed [11:0] w_pad_lo;
  logic signed [11:0] w_pad_hi;
  logic        w_x_wall;
  logic        w_top;
  logic        w_bottom;
  logic        w_paddle;
  logic [11:0] w_hit_mask;
  logic        w_brick_ok;
  logic        w_y_brick;
  logic        w_y_bounce;
  logic [11:0] w_alive_next;

  assign w_nx = r_dir[0] ? (signed'({1'b0, r_ball_x}) - signed'(11'(XSTEP)))
                         : (signed'({1'b0, r_ball_x}) + signed'(11'(XSTEP)));
  assign w_ny = r_dir[1] ? (signed'({1'b0, r_ball_y}) - signed'(11'(YSTEP)))
                         : (signed'({1'b0, r_ball_y}) + signed'(11'(YSTEP)));

  assign w_x_wall = (w_nx < 11'sd0) || (w_nx > signed'(11'(SCREEN_W - 1)));
  assign w_top    = (w_ny < 11'sd0);
  assign w_bottom = (w_ny > signed'(11'(SCREEN_H - 1)));

  // Paddle span compared in 12-bit signed space: paddle_x + PADDLE_W - 1
  // can exceed 10 bits and nx can be negative.
  assign w_nx_ext = {w_nx[10], w_nx};
  assign w_pad_lo = signed'({2'b00, paddle_x});
  assign w_pad_hi = w_pad_lo + signed'(12'(PADDLE_W - 1));
  assign w_paddle = !r_dir[1]
                 && (r_ball_y < 10'(PADDLE_Y))
                 && (w_ny >= signed'(11'(PADDLE_Y)))
                 && (w_nx_ext >= w_pad_lo) && (w_nx_ext <= w_pad_hi);

  // A shift by 12..15 leaves an all-zero mask, so no-brick codes never match.
  assign w_hit_mask = 12'd1 << r_hit;
  assign w_brick_ok = (r_hit < 4'd12) && (|(r_alive & w_hit_mask));

  // y-axis priority: top wall, then paddle, then brick (bottom handled by FSM).
  assign w_y_brick    = !w_top && !w_paddle && w_brick_ok;
  assign w_y_bounce   = w_top || w_paddle || w_y_brick;
  assign w_alive_next = w_y_brick ? (r_alive & ~w_hit_mask) : r_alive;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_WAIT;
      S_WAIT:  if (frame_tick) w_next = S_PROBE;
      S_PROBE: w_next = S_EVAL;
      S_EVAL: begin
        if (w_bottom)                w_next = S_LOST;
        else if (w_alive_next == '0) w_next = S_WIN;
        else                         w_next = S_WAIT;
      end
      S_LOST:  if (start) w_next = S_WAIT;
      S_WIN:   if (start) w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ball_x  <= 10'(START_X);
      r_ball_y  <= 10'(START_Y);
      r_probe_x <= 10'(START_X);
      r_probe_y <= 10'(START_Y);
      r_dir     <= 2'b10;
      r_alive   <= 12'hFFF;
      r_hit     <= 4'hF;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_WAIT: begin
          if (frame_tick) begin
            r_probe_x <= w_nx[9:0];
            r_probe_y <= w_ny[9:0];
          end
        end
        S_PROBE: r_hit <= probe_brick;
        S_EVAL: begin
          r_done <= 1'b1;
          // Falling off the bottom freezes position and direction.
          if (!w_bottom) begin
            if (w_x_wall) r_dir[0]  <= ~r_dir[0];
            else          r_ball_x  <= w_nx[9:0];
            if (w_y_bounce) r_dir[1] <= ~r_dir[1];
            else            r_ball_y <= w_ny[9:0];
            r_alive <= w_alive_next;
          end
        end
        S_LOST, S_WIN: begin
          // Relaunch parks the ball at the start point heading up and right;
          // only a win refills the brick field.
          if (start) begin
            r_ball_x  <= 10'(START_X);
            r_ball_y  <= 10'(START_Y);
            r_probe_x <= 10'(START_X);
            r_probe_y <= 10'(START_Y);
            r_dir     <= 2'b10;
            if (r_state == S_WIN) r_alive <= 12'hFFF;
          end
        end
        default: ;
      endcase
    end
  end

  assign probe_x      = r_probe_x;
  assign probe_y      = r_probe_y;
  assign ball_x       = r_ball_x;
  assign ball_y       = r_ball_y;
  assign dir          = r_dir;
  assign bricks_alive = r_alive;
  assign busy         = (r_state == S_PROBE) || (r_state == S_EVAL);
  assign done         = r_done;
  assign lost         = (r_state == S_LOST);
  assign win          = (r_state == S_WIN);
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  paddle_x = 10'd0;
  logic [9:0]  probe_x, probe_y;
  logic [3:0]  probe_brick = 4'hF;
  logic [9:0]  ball_x, ball_y;
  logic [1:0]  dir;
  logic [11:0] bricks_alive;
  logic        busy, done, lost, win;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: game state at the level of the rules.
  int          m_x, m_y;
  logic [1:0]  m_dir;
  logic [11:0] m_alive;
  bit          m_lost, m_win;

  ball_motion_ctrl dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start),
    .paddle_x(paddle_x), .probe_x(probe_x), .probe_y(probe_y),
    .probe_brick(probe_brick), .ball_x(ball_x), .ball_y(ball_y), .dir(dir),
    .bricks_alive(bricks_alive), .busy(busy), .done(done), .lost(lost),
    .win(win), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_x = 320; m_y = 400; m_dir = 2'b10; m_alive = 12'hFFF;
    m_lost = 0; m_win = 0;
  endtask

  function automatic int m_nx();
    return m_dir[0] ? m_x - 4 : m_x + 4;
  endfunction

  function automatic int m_ny();
    return m_dir[1] ? m_y - 4 : m_y + 4;
  endfunction

  task automatic m_frame(input logic [3:0] brick, input int pad);
    int  nx, ny;
    bit  yb;
    nx = m_nx(); ny = m_ny();
    if (ny > 479) begin
      m_lost = 1;
    end else begin
      if (nx < 0 || nx > 639) m_dir[0] = ~m_dir[0];
      else                    m_x = nx;
      yb = 0;
      if (ny < 0) yb = 1;
      else if (!m_dir[1] && m_y < 440 && ny >= 440 && nx >= pad && nx <= pad + 79) yb = 1;
      else if (brick < 12 && m_alive[brick]) begin
        m_alive[brick] = 1'b0;
        yb = 1;
      end
      if (yb) m_dir[1] = ~m_dir[1];
      else    m_y = ny;
      if (m_alive == 12'h000) m_win = 1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_vec++;
    if ({ball_x, ball_y, probe_x, probe_y, dir, bricks_alive, busy, done, lost, win} !==
        {10'd320, 10'd400, 10'd320, 10'd400, 2'b10, 12'hFFF, 4'b0000}) begin
      n_err++;
      $display("FAIL %s got ball=(%0d,%0d) probe=(%0d,%0d) dir=%b alive=%h busy=%b done=%b lost=%b win=%b, need (320,400) (320,400) 10 fff 0 0 0 0",
               tag, ball_x, ball_y, probe_x, probe_y, dir, bricks_alive, busy, done, lost, win);
    end
  endtask

  // Runs one frame starting at a negedge with the DUT in WAIT. junk drives
  // stray start pulses and extra ticks while busy; b2b returns at the T+3
  // negedge so the next frame_tick lands in T+3.
  task automatic do_frame(input logic [3:0] brick, input logic [9:0] pad,
                          input bit junk, input bit b2b);
    int enx, eny;
    enx = m_nx(); eny = m_ny();
    paddle_x = pad;
    frame_tick = 1'b1;
    start = junk;
    @(negedge clk);                       // T+1
    frame_tick = junk;
    probe_brick = brick;
    n_vec++;
    if ({busy, done, probe_x, probe_y} !== {1'b1, 1'b0, 10'(enx), 10'(eny)}) begin
      n_err++;
      $display("FAIL frame_t1 got busy=%b done=%b probe=(%0d,%0d) need busy=1 done=0 probe=(%0d,%0d)",
               busy, done, probe_x, probe_y, 10'(enx), 10'(eny));
    end
    @(negedge clk);                       // T+2
    n_vec++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL frame_t2 got busy=%b done=%b need busy=1 done=0", busy, done);
    end
    frame_tick = 1'b0;
    start = 1'b0;
    probe_brick = 4'($urandom_range(0, 15));
    m_frame(brick, int'(pad));
    @(negedge clk);                       // T+3
    n_vec++;
    if ({ball_x, ball_y, dir, bricks_alive, busy, done, lost, win} !==
        {10'(m_x), 10'(m_y), m_dir, m_alive, 1'b0, 1'b1, m_lost, m_win}) begin
      n_err++;
      $display("FAIL frame_t3 got ball=(%0d,%0d) dir=%b alive=%h busy=%b done=%b lost=%b win=%b need (%0d,%0d) dir=%b alive=%h busy=0 done=1 lost=%b win=%b",
               ball_x, ball_y, dir, bricks_alive, busy, done, lost, win,
               m_x, m_y, m_dir, m_alive, m_lost, m_win);
    end
    if (!b2b) begin
      @(negedge clk);                     // T+4: dropped ticks left no frame running
      n_vec++;
      if ({busy, done, lost, win} !== {1'b0, 1'b0, m_lost, m_win}) begin
        n_err++;
        $display("FAIL frame_t4 got busy=%b done=%b lost=%b win=%b need busy=0 done=0 lost=%b win=%b",
                 busy, done, lost, win, m_lost, m_win);
      end
    end
  endtask

  // From LOST or WIN: a tick is ignored, then start relaunches.
  task automatic relaunch();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_vec++;
    if ({busy, lost, win} !== {1'b0, m_lost, m_win}) begin
      n_err++;
      $display("FAIL end_hold got busy=%b lost=%b win=%b need busy=0 lost=%b win=%b",
               busy, lost, win, m_lost, m_win);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_win) m_alive = 12'hFFF;
    m_x = 320; m_y = 400; m_dir = 2'b10; m_lost = 0; m_win = 0;
    n_vec++;
    if ({ball_x, ball_y, dir, bricks_alive, busy, lost, win} !==
        {10'd320, 10'd400, 2'b10, m_alive, 3'b000}) begin
      n_err++;
      $display("FAIL relaunch got ball=(%0d,%0d) dir=%b alive=%h busy=%b lost=%b win=%b need (320,400) dir=10 alive=%h 0 0 0",
               ball_x, ball_y, dir, bricks_alive, busy, lost, win, m_alive);
    end
  endtask

  function automatic logic [3:0] rand_brick();
    if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 11));
    return 4'($urandom_range(12, 15));
  endfunction

  function automatic logic [9:0] rand_pad();
    int p;
    if ($urandom_range(0, 1) == 0) return 10'($urandom_range(0, 560));
    p = m_x - int'($urandom_range(0, 84));
    if (p < 0) p = 0;
    return 10'(p);
  endfunction

  function automatic logic [3:0] lowest_alive();
    for (int i = 0; i < 12; i++) if (m_alive[i]) return 4'(i);
    return 4'hF;
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_state");
    resetn = 1'b1;
    frame_tick = 1'b1;                    // IDLE ignores ticks
    @(negedge clk);
    frame_tick = 1'b0;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_tick got busy=%b need 0", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_first_frame();
    do_frame(4'hF, 10'd0, 1'b0, 1'b0);
    n_vec++;
    if ({ball_x, ball_y, dir} !== {10'd324, 10'd396, 2'b10}) begin
      n_err++;
      $display("FAIL first_frame got (%0d,%0d) dir=%b need (324,396) dir=10", ball_x, ball_y, dir);
    end
  endtask

  task automatic test_random_play();
    for (int i = 0; i < 300; i++) begin
      do_frame(rand_brick(), rand_pad(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (m_lost || m_win) relaunch();
    end
  endtask

  task automatic test_win();
    int guard;
    guard = 0;
    while (!m_win && guard < 200) begin
      do_frame(lowest_alive(), rand_pad(), 1'b0, 1'($urandom_range(0, 1)));
      if (m_lost) relaunch();
      guard++;
    end
    n_vec++;
    if (!m_win || win !== 1'b1 || bricks_alive !== 12'h000) begin
      n_err++;
      $display("FAIL win_reach got win=%b alive=%h after %0d frames need win=1 alive=000",
               win, bricks_alive, guard);
    end
    if (m_win) relaunch();
  endtask

  task automatic test_reset_mid_frame();
    frame_tick = 1'b1;
    @(negedge clk);                       // PROBE
    frame_tick = 1'b0;
    probe_brick = lowest_alive();
    @(negedge clk);                       // EVAL
    resetn = 1'b0;
    #1;
    m_reset();
    check_reset_values("reset_mid_eval");
    @(negedge clk);
    resetn = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    do_frame(4'hF, 10'd0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_random_play();
    test_win();
    test_reset_mid_frame();
    test_random_play();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
